// File: rtl/doodle_pkg.sv
// Shared game-state encoding and keyboard constants for the Doodle Jump motion engine.
package doodle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } game_state_e;

    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_LEFT  = 8'd80;

    function automatic logic key_is_right(input logic [7:0] key);
        return (key == KEY_D) || (key == KEY_RIGHT);
    endfunction

    function automatic logic key_is_left(input logic [7:0] key);
        return (key == KEY_A) || (key == KEY_LEFT);
    endfunction

endpackage

// File: rtl/doodle_x_axis.sv
// Horizontal motion: keycode decode, per-frame step and wrap-around at the playfield edges.
module doodle_x_axis
    import doodle_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int X_CENTER = 320,
    parameter int X_SPEED  = 2
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_tick,
    input  logic           enable,
    input  logic           spawn,
    input  logic [7:0]     keycode,
    output logic [X_W-1:0] pos_x
);

    localparam logic [X_W:0]   MIN_W    = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]   MAX_W    = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   SPEED_W  = (X_W+1)'(X_SPEED);
    localparam logic [X_W-1:0] CENTER_V = X_W'(X_CENTER);

    logic [X_W-1:0] pos_x_r;
    logic [X_W-1:0] x_step_s;
    logic [X_W:0]   x_wide_s;
    logic [X_W:0]   x_right_s;
    logic [X_W:0]   x_left_s;

    assign x_wide_s  = {1'b0, pos_x_r};
    assign x_right_s = x_wide_s + SPEED_W;
    assign x_left_s  = x_wide_s - SPEED_W;

    // Next X for the held key, wrapping to the opposite edge when leaving the playfield
    always_comb begin
        x_step_s = pos_x_r;
        if (key_is_right(keycode)) begin
            if (x_right_s > MAX_W) begin
                x_step_s = MIN_W[X_W-1:0];
            end else begin
                x_step_s = x_right_s[X_W-1:0];
            end
        end else if (key_is_left(keycode)) begin
            if (x_wide_s < (MIN_W + SPEED_W)) begin
                x_step_s = MAX_W[X_W-1:0];
            end else begin
                x_step_s = x_left_s[X_W-1:0];
            end
        end else begin
            x_step_s = pos_x_r;
        end
    end

    // X position register; spawn reload wins over the frame step
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x_r <= CENTER_V;
        end else if (spawn) begin
            pos_x_r <= CENTER_V;
        end else if (enable && frame_tick) begin
            pos_x_r <= x_step_s;
        end else begin
            pos_x_r <= pos_x_r;
        end
    end

    assign pos_x = pos_x_r;

endmodule

// File: rtl/doodle_physics.sv
// Doodle Jump character motion: Y physics under gravity, platform bounce, scroll request
// and the IDLE/PLAY/DEAD game state; X motion is delegated to doodle_x_axis.
module doodle_physics
    import doodle_pkg::*;
#(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int VEL_W       = 8,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_CENTER    = 320,
    parameter int Y_CENTER    = 240,
    parameter int SIZE        = 4,
    parameter int GRAVITY     = 1,
    parameter int JUMP_VEL    = 12,
    parameter int SPRING_VEL  = 20,
    parameter int MAX_FALL    = 10,
    parameter int X_SPEED     = 2,
    parameter int SCROLL_LINE = 160
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic [7:0]              keycode,
    input  logic                    start,
    input  logic                    land_hit,
    input  logic                    spring_hit,
    output logic [X_W-1:0]          pos_x,
    output logic [Y_W-1:0]          pos_y,
    output logic signed [VEL_W-1:0] vel_y,
    output logic [1:0]              state,
    output logic                    jump_pulse,
    output logic [Y_W-1:0]          scroll_amt,
    output logic                    dead
);

    localparam int YS_W = Y_W + 2;

    localparam logic signed [YS_W-1:0]  Y_MAX_S    = YS_W'(Y_MAX);
    localparam logic signed [YS_W-1:0]  SIZE_S     = YS_W'(SIZE);
    localparam logic signed [YS_W-1:0]  SCROLL_S   = YS_W'(SCROLL_LINE);
    localparam logic [Y_W-1:0]          Y_SPAWN    = Y_W'(Y_CENTER);
    localparam logic [Y_W-1:0]          SCROLL_Y   = Y_W'(SCROLL_LINE);
    localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(-JUMP_VEL);
    localparam logic signed [VEL_W-1:0] SPRING_V   = VEL_W'(-SPRING_VEL);
    localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W:0]   GRAV_S     = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   MAX_FALL_S = (VEL_W+1)'(MAX_FALL);

    game_state_e             state_r,  state_nxt_s;
    logic [Y_W-1:0]          pos_y_r,  pos_y_nxt_s;
    logic signed [VEL_W-1:0] vel_y_r,  vel_nxt_s;
    logic [Y_W-1:0]          scroll_r, scroll_nxt_s;
    logic                    jump_r,   jump_nxt_s;
    logic                    dead_r,   dead_nxt_s;

    logic signed [YS_W-1:0]  y_next_s;
    logic signed [YS_W-1:0]  scroll_diff_s;
    logic signed [VEL_W:0]   vel_inc_s;
    logic signed [VEL_W-1:0] vel_grav_s;
    logic                    die_s;
    logic                    bounce_s;
    logic                    x_spawn_s;

    // Position and velocity are widened to a common signed range so upward motion
    // past the top edge and the death test near the bottom compare correctly.
    assign y_next_s      = $signed({2'b00, pos_y_r})
                         + $signed({{(YS_W-VEL_W){vel_y_r[VEL_W-1]}}, vel_y_r});
    assign scroll_diff_s = SCROLL_S - y_next_s;
    assign die_s         = (y_next_s + SIZE_S) > Y_MAX_S;
    assign bounce_s      = land_hit && !vel_y_r[VEL_W-1];
    assign vel_inc_s     = $signed({vel_y_r[VEL_W-1], vel_y_r}) + GRAV_S;
    assign vel_grav_s    = (vel_inc_s > MAX_FALL_S) ? MAX_FALL_V : vel_inc_s[VEL_W-1:0];
    assign x_spawn_s     = (state_r == DEAD) && start;

    // Game-state FSM and per-frame Y physics
    always_comb begin
        state_nxt_s  = state_r;
        pos_y_nxt_s  = pos_y_r;
        vel_nxt_s    = vel_y_r;
        scroll_nxt_s = scroll_r;
        jump_nxt_s   = 1'b0;
        dead_nxt_s   = dead_r;
        case (state_r)
            IDLE: begin
                pos_y_nxt_s  = Y_SPAWN;
                scroll_nxt_s = '0;
                dead_nxt_s   = 1'b0;
                if (start) begin
                    state_nxt_s = PLAY;
                    vel_nxt_s   = JUMP_V;
                end else begin
                    vel_nxt_s   = '0;
                end
            end
            PLAY: begin
                if (!frame_tick) begin
                    state_nxt_s = PLAY;
                end else if (die_s) begin
                    state_nxt_s  = DEAD;
                    vel_nxt_s    = '0;
                    scroll_nxt_s = '0;
                    dead_nxt_s   = 1'b1;
                end else begin
                    if (bounce_s) begin
                        vel_nxt_s  = spring_hit ? SPRING_V : JUMP_V;
                        jump_nxt_s = 1'b1;
                    end else begin
                        vel_nxt_s  = vel_grav_s;
                    end
                    if (y_next_s < SCROLL_S) begin
                        pos_y_nxt_s  = SCROLL_Y;
                        scroll_nxt_s = scroll_diff_s[Y_W-1:0];
                    end else begin
                        pos_y_nxt_s  = y_next_s[Y_W-1:0];
                        scroll_nxt_s = '0;
                    end
                end
            end
            DEAD: begin
                if (start) begin
                    state_nxt_s  = IDLE;
                    pos_y_nxt_s  = Y_SPAWN;
                    vel_nxt_s    = '0;
                    scroll_nxt_s = '0;
                    dead_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s  = DEAD;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                pos_y_nxt_s  = Y_SPAWN;
                vel_nxt_s    = '0;
                scroll_nxt_s = '0;
                dead_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and Y-axis output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            pos_y_r  <= Y_SPAWN;
            vel_y_r  <= '0;
            scroll_r <= '0;
            jump_r   <= 1'b0;
            dead_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pos_y_r  <= pos_y_nxt_s;
            vel_y_r  <= vel_nxt_s;
            scroll_r <= scroll_nxt_s;
            jump_r   <= jump_nxt_s;
            dead_r   <= dead_nxt_s;
        end
    end

    doodle_x_axis #(
        .X_W      (X_W),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .X_CENTER (X_CENTER),
        .X_SPEED  (X_SPEED)
    ) u_x_axis (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .enable     (state_r == PLAY),
        .spawn      (x_spawn_s),
        .keycode    (keycode),
        .pos_x      (pos_x)
    );

    assign pos_y      = pos_y_r;
    assign vel_y      = vel_y_r;
    assign state      = state_r;
    assign jump_pulse = jump_r;
    assign scroll_amt = scroll_r;
    assign dead       = dead_r;

endmodule

// File: tb/tb_doodle_physics.sv
// Self-checking bench for doodle_physics: directed scenarios plus random frames against a plain-arithmetic game model.
module tb_doodle_physics;

    logic        Clk;
    logic        clk_en;
    logic        Reset_n;
    logic        frame_tick;
    logic [7:0]  keycode;
    logic        start;
    logic        land_hit;
    logic        spring_hit;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic signed [7:0] vel_y;
    logic [1:0]  state;
    logic        jump_pulse;
    logic [9:0]  scroll_amt;
    logic        dead;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Game model: 0 = idle, 1 = play, 2 = dead
    int m_x, m_y, m_v, m_state, m_scroll, m_jump;

    doodle_physics dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .start      (start),
        .land_hit   (land_hit),
        .spring_hit (spring_hit),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vel_y      (vel_y),
        .state      (state),
        .jump_pulse (jump_pulse),
        .scroll_amt (scroll_amt),
        .dead       (dead)
    );

    always #5 if (clk_en) Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 240; m_v = 0; m_state = 0; m_scroll = 0; m_jump = 0;
    endtask

    task automatic model_cycle(input bit tk, input logic [7:0] kc, input bit lh, input bit sh, input bit st);
        int yn;
        m_jump = 0;
        if (m_state == 0) begin
            m_x = 320; m_y = 240; m_v = 0; m_scroll = 0;
            if (st) begin
                m_state = 1;
                m_v = -12;
            end
        end else if (m_state == 1) begin
            if (tk) begin
                if (kc == 8'd7 || kc == 8'd79) begin
                    m_x = m_x + 2;
                    if (m_x > 639) m_x = 0;
                end else if (kc == 8'd4 || kc == 8'd80) begin
                    if (m_x < 2) m_x = 639;
                    else m_x = m_x - 2;
                end
                yn = m_y + m_v;
                if (yn + 4 > 479) begin
                    m_state = 2; m_v = 0; m_scroll = 0;
                end else begin
                    if (lh && m_v >= 0) begin
                        m_v = sh ? -20 : -12;
                        m_jump = 1;
                    end else begin
                        m_v = (m_v + 1 > 10) ? 10 : m_v + 1;
                    end
                    if (yn < 160) begin
                        m_scroll = 160 - yn; m_y = 160;
                    end else begin
                        m_y = yn; m_scroll = 0;
                    end
                end
            end
        end else begin
            if (st) begin
                m_state = 0; m_x = 320; m_y = 240; m_v = 0; m_scroll = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},      pos_x,           m_x);
        chk({tag, ".y"},      pos_y,           m_y);
        chk({tag, ".vel"},    $signed(vel_y),  m_v);
        chk({tag, ".state"},  state,           m_state);
        chk({tag, ".jump"},   jump_pulse,      m_jump);
        chk({tag, ".scroll"}, scroll_amt,      m_scroll);
        chk({tag, ".dead"},   dead,            (m_state == 2) ? 1 : 0);
    endtask

    task automatic cycle(input bit tk, input logic [7:0] kc, input bit lh, input bit sh, input bit st);
        frame_tick = tk; keycode = kc; land_hit = lh; spring_hit = sh; start = st;
        @(posedge Clk);
        model_cycle(tk, kc, lh, sh, st);
        #1;
        frame_tick = 1'b0; land_hit = 1'b0; spring_hit = 1'b0; start = 1'b0;
        check_all("cyc");
    endtask

    task automatic fall_and_bounce(input int target);
        int n = 0;
        while ((m_y + m_v) != target && n < 60) begin
            cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        cycle(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rise_to_apex();
        int n = 0;
        while (m_v != 0 && n < 30) begin
            cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] keys [6];
        keys = '{8'd7, 8'd79, 8'd4, 8'd80, 8'd0, 8'd55};
        Clk = 1'b0; clk_en = 1'b0;
        frame_tick = 1'b0; keycode = 8'd0; start = 1'b0; land_hit = 1'b0; spring_hit = 1'b0;

        // Reset with the clock stopped
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #2;
        model_reset();
        chk("rst.x", pos_x, 320);
        chk("rst.y", pos_y, 240);
        chk("rst.vel", $signed(vel_y), 0);
        chk("rst.state", state, 0);
        chk("rst.dead", dead, 0);
        chk("rst.scroll", scroll_amt, 0);
        Reset_n = 1'b1;
        #1 clk_en = 1'b1;

        // Launch: start together with a tick must not move the player
        cycle(1'b1, 8'd79, 1'b1, 1'b0, 1'b1);
        chk("launch.x", pos_x, 320);
        chk("launch.y", pos_y, 240);
        chk("launch.vel", $signed(vel_y), -12);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
            if (i == 1) chk("launch.t1", pos_y, 228);
            if (i == 2) chk("launch.t2", pos_y, 217);
            chk("launch.scroll", scroll_amt, 0);
        end
        chk("launch.t12.y", pos_y, 162);
        chk("launch.t12.vel", $signed(vel_y), 0);

        // Bounce at vel 3, then ignored hit at vel -5
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_bounce.vel", $signed(vel_y), 3);
        cycle(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("bounce.vel", $signed(vel_y), -12);
        chk("bounce.pulse", jump_pulse, 1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("bounce.pulse_end", jump_pulse, 0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_ignore.vel", $signed(vel_y), -5);
        cycle(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("ignore.vel", $signed(vel_y), -4);
        chk("ignore.pulse", jump_pulse, 0);

        // Horizontal wrap while bouncing to stay alive
        n = 0;
        while (m_x != 638 && n < 400) begin
            cycle(1'b1, 8'd79, (m_v >= 0), 1'b0, 1'b0);
            n++;
        end
        chk("wrap.at638", pos_x, 638);
        cycle(1'b1, 8'd7, (m_v >= 0), 1'b0, 1'b0);
        chk("wrap.right", pos_x, 0);
        n = 0;
        while (m_x != 1 && n < 400) begin
            cycle(1'b1, 8'd80, (m_v >= 0), 1'b0, 1'b0);
            n++;
        end
        chk("wrap.at1", pos_x, 1);
        cycle(1'b1, 8'd4, (m_v >= 0), 1'b0, 1'b0);
        chk("wrap.left", pos_x, 639);
        cycle(1'b1, 8'd0, (m_v >= 0), 1'b0, 1'b0);
        chk("wrap.none", pos_x, 639);

        // Steer to y = 200, vel = 0 via two ordinary bounces
        rise_to_apex();
        chk("apex160.y", pos_y, 160);
        fall_and_bounce(335);
        rise_to_apex();
        chk("apex257.y", pos_y, 257);
        fall_and_bounce(278);
        rise_to_apex();
        chk("apex200.y", pos_y, 200);
        chk("apex200.vel", $signed(vel_y), 0);

        // Spring bounce and scroll
        cycle(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("spring.y", pos_y, 200);
        chk("spring.vel", $signed(vel_y), -20);
        chk("spring.pulse", jump_pulse, 1);
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("spring.t1", pos_y, 180);
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("spring.t2", pos_y, 161);
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("scroll.y", pos_y, 160);
        chk("scroll.amt", scroll_amt, 17);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("scroll.hold", scroll_amt, 17);
        rise_to_apex();
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("scroll.clear", scroll_amt, 0);

        // Free fall to death, then restart
        n = 0;
        while (m_state != 2 && n < 100) begin
            cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
            if (m_v == 10) chk("fall.sat", $signed(vel_y), 10);
            n++;
        end
        chk("death.state", state, 2);
        chk("death.dead", dead, 1);
        chk("death.y", pos_y, 475);
        chk("death.vel", $signed(vel_y), 0);
        cycle(1'b1, 8'd79, 1'b1, 1'b0, 1'b0);
        chk("dead.frozen", pos_y, 475);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("restart.state", state, 0);
        chk("restart.x", pos_x, 320);
        chk("restart.y", pos_y, 240);

        // Asynchronous reset in the middle of play
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'd79, 1'b0, 1'b0, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.x", pos_x, 320);
        chk("midrst.y", pos_y, 240);
        chk("midrst.vel", $signed(vel_y), 0);
        chk("midrst.state", state, 0);
        chk("midrst.dead", dead, 0);
        Reset_n = 1'b1;

        // Random frames against the model
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 3) != 0), keys[$urandom_range(0, 5)],
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
